// File: rtl/ps2_direction_decoder.sv
// PS/2 set-2 scan code interpreter for the snake game: arrows steer (WASD too when WASD_EN is defined), space toggles pause.
// Latency 1 cycle from the newkeyStrobe edge; no backpressure, every strobed byte is consumed.
module ps2_direction_decoder #(
  parameter int         TIMEOUT_CYCLES = 2000000,
  parameter logic [1:0] INIT_DIR       = 2'b11
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [7:0] keycode,
  input  logic       newkeyStrobe,
  output logic [1:0] dir,
  output logic       dir_pulse,
  output logic       pause,
  output logic       seq_err
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  localparam logic [7:0] K_EXT   = 8'hE0;
  localparam logic [7:0] K_BRK   = 8'hF0;
  localparam logic [7:0] K_SPACE = 8'h29;
  localparam logic [7:0] K_UP    = 8'h75;
  localparam logic [7:0] K_DOWN  = 8'h72;
  localparam logic [7:0] K_LEFT  = 8'h6B;
  localparam logic [7:0] K_RIGHT = 8'h74;

  localparam logic [1:0] D_UP    = 2'b00;
  localparam logic [1:0] D_DOWN  = 2'b01;
  localparam logic [1:0] D_LEFT  = 2'b10;
  localparam logic [1:0] D_RIGHT = 2'b11;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          space_held;
  logic          cand_vld;
  logic [1:0]    cand;
  logic          accept;

  always_comb begin
    cand_vld = 1'b0;
    cand     = dir;
    if (newkeyStrobe) begin
      if (state == EXT) begin
        case (keycode)
          K_UP:    begin cand_vld = 1'b1; cand = D_UP;    end
          K_DOWN:  begin cand_vld = 1'b1; cand = D_DOWN;  end
          K_LEFT:  begin cand_vld = 1'b1; cand = D_LEFT;  end
          K_RIGHT: begin cand_vld = 1'b1; cand = D_RIGHT; end
          default: cand_vld = 1'b0;
        endcase
      end
`ifdef WASD_EN
      else if (state == IDLE) begin
        case (keycode)
          8'h1D:   begin cand_vld = 1'b1; cand = D_UP;    end
          8'h1B:   begin cand_vld = 1'b1; cand = D_DOWN;  end
          8'h1C:   begin cand_vld = 1'b1; cand = D_LEFT;  end
          8'h23:   begin cand_vld = 1'b1; cand = D_RIGHT; end
          default: cand_vld = 1'b0;
        endcase
      end
`endif
    end
  end

  // Opposite headings differ only in bit 0, so a turn is legal only across the up/down vs left/right axis.
  assign accept = cand_vld && !pause && (cand != dir) && ((cand ^ dir) != 2'b01);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= IDLE;
      cnt        <= '0;
      space_held <= 1'b0;
      dir        <= INIT_DIR;
      dir_pulse  <= 1'b0;
      pause      <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      dir_pulse <= 1'b0;
      seq_err   <= 1'b0;
      if (accept) begin
        dir       <= cand;
        dir_pulse <= 1'b1;
      end
      if (newkeyStrobe) begin
        cnt <= '0;
        case (state)
          IDLE: begin
            if (keycode == K_EXT) begin
              state <= EXT;
            end else if (keycode == K_BRK) begin
              state <= BRK;
            end else if (keycode == K_SPACE && !space_held) begin
              pause      <= ~pause;
              space_held <= 1'b1;
            end
          end
          EXT: begin
            if (keycode == K_BRK) begin
              state <= EXT_BRK;
            end else if (keycode != K_EXT) begin
              state <= IDLE;
            end
          end
          BRK: begin
            if (keycode == K_SPACE) begin
              space_held <= 1'b0;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A strobe on the expiry cycle is taken by the branch above instead.
        if (cnt == CNT_LAST) begin
          state   <= IDLE;
          seq_err <= 1'b1;
          cnt     <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Scoreboard bench for ps2_direction_decoder: a reference model queues expected outputs per consumed byte.
module tb_ps2_direction_decoder;

  localparam int         T    = 16;
  localparam logic [1:0] INIT = 2'b11;
  localparam int S_IDLE = 0, S_EXT = 1, S_BRK = 2, S_EXT_BRK = 3;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic [7:0] keycode;
  logic       newkeyStrobe;
  logic [1:0] dir;
  logic       dir_pulse, pause, seq_err;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [4:0] exp_q[$];

  logic [1:0] m_dir;
  logic       m_pause, m_held;
  int         m_state, m_cnt;
  int         seq_seen = 0;

  always #5 CLK = ~CLK;

  ps2_direction_decoder #(.TIMEOUT_CYCLES(T), .INIT_DIR(INIT)) dut (
    .CLK(CLK), .RESETN(RESETN), .keycode(keycode), .newkeyStrobe(newkeyStrobe),
    .dir(dir), .dir_pulse(dir_pulse), .pause(pause), .seq_err(seq_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] opposite(input logic [1:0] d);
    case (d)
      2'b00:   return 2'b01;
      2'b01:   return 2'b00;
      2'b10:   return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] k, output logic [4:0] e);
    logic       cv;
    logic [1:0] c;
    logic       pulse;
    cv = 1'b0; c = 2'b00; pulse = 1'b0;
    m_cnt = 0;
    case (m_state)
      S_IDLE: begin
        if (k == 8'hE0) m_state = S_EXT;
        else if (k == 8'hF0) m_state = S_BRK;
        else if (k == 8'h29) begin
          if (!m_held) begin m_pause = !m_pause; m_held = 1'b1; end
        end
`ifdef WASD_EN
        else if (k == 8'h1D) begin cv = 1'b1; c = 2'b00; end
        else if (k == 8'h1B) begin cv = 1'b1; c = 2'b01; end
        else if (k == 8'h1C) begin cv = 1'b1; c = 2'b10; end
        else if (k == 8'h23) begin cv = 1'b1; c = 2'b11; end
`endif
      end
      S_EXT: begin
        if (k == 8'h75) begin cv = 1'b1; c = 2'b00; end
        else if (k == 8'h72) begin cv = 1'b1; c = 2'b01; end
        else if (k == 8'h6B) begin cv = 1'b1; c = 2'b10; end
        else if (k == 8'h74) begin cv = 1'b1; c = 2'b11; end
        if (k == 8'hF0) m_state = S_EXT_BRK;
        else if (k != 8'hE0) m_state = S_IDLE;
      end
      S_BRK: begin
        if (k == 8'h29) m_held = 1'b0;
        m_state = S_IDLE;
      end
      default: m_state = S_IDLE;
    endcase
    if (cv && !m_pause && c != m_dir && c != opposite(m_dir)) begin
      m_dir = c;
      pulse = 1'b1;
    end
    e = {m_dir, pulse, m_pause, 1'b0};
  endtask

  always @(posedge CLK) begin : monitor
    logic       st;
    logic [4:0] e;
    logic [4:0] got;
    if (!RESETN) begin
      m_dir = INIT; m_pause = 1'b0; m_held = 1'b0; m_state = S_IDLE; m_cnt = 0;
    end else begin
      st = newkeyStrobe;
      if (st) begin
        model_byte(keycode, e);
        exp_q.push_back(e);
      end else begin
        e = {m_dir, 1'b0, m_pause, 1'b0};
        if (m_state != S_IDLE) begin
          if (m_cnt == T - 1) begin
            m_state = S_IDLE; m_cnt = 0; e[0] = 1'b1;
          end else begin
            m_cnt++;
          end
        end
      end
      #1;
      got = {dir, dir_pulse, pause, seq_err};
      if (st) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", 1, 0);
        else check_eq("strobe_out", 32'(got), 32'(exp_q.pop_front()));
      end else begin
        check_eq("idle_out", 32'(got), 32'(e));
      end
      if (got[0]) seq_seen++;
    end
  end

  task automatic send(input logic [7:0] k);
    @(negedge CLK);
    keycode = k;
    newkeyStrobe = 1'b1;
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    newkeyStrobe = 1'b0;
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    newkeyStrobe = 1'b0;
    RESETN = 1'b0;
    #1;
    check_eq("async_reset", 32'({dir, dir_pulse, pause, seq_err}), 32'({INIT, 3'b000}));
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    RESETN = 1'b0; newkeyStrobe = 1'b0; keycode = 8'h00;
    repeat (2) @(negedge CLK);
    check_eq("reset_vals", 32'({dir, dir_pulse, pause, seq_err}), 32'({INIT, 3'b000}));
    RESETN = 1'b1;

    send(8'hE0); send(8'h75); idle(3);
    check_eq("arrow_up", 32'(dir), 32'h0);
    send(8'hE0); send(8'h72); idle(2);
    check_eq("reversal_blocked", 32'(dir), 32'h0);
    send(8'hE0); send(8'h6B); idle(2);
    check_eq("arrow_left", 32'(dir), 32'h2);

    send(8'h29); send(8'h29); send(8'h29); send(8'hF0); send(8'h29); send(8'h29); idle(2);
    check_eq("pause_final", 32'(pause), 32'h0);

    send(8'hF0); send(8'h29); send(8'h29); idle(2);
    check_eq("pause_set", 32'(pause), 32'h1);
    send(8'hE0); send(8'h75); idle(2);
    check_eq("paused_hold", 32'(dir), 32'h2);
    send(8'hF0); send(8'h29); send(8'h29); idle(1);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h74); idle(2);
    check_eq("unpaused_right", 32'(dir), 32'h3);

    send(8'hE0); send(8'hF0); send(8'h74); idle(1);
    send(8'hE0); send(8'hE0); send(8'h72); idle(2);
    check_eq("double_e0_down", 32'(dir), 32'h1);

    send(8'hE0); idle(T + 3);
    check_eq("seq_err_count", 32'(seq_seen), 32'd1);
    send(8'h75); idle(2);
    check_eq("orphan_75", 32'(dir), 32'h1);

    send(8'hE0); idle(T - 1); send(8'h6B); idle(3);
    check_eq("strobe_beats_timeout", 32'(dir), 32'h2);
    check_eq("no_err_on_priority", 32'(seq_seen), 32'd1);

    do_reset();
    send(8'h1D); idle(2);
`ifdef WASD_EN
    check_eq("wasd_w", 32'(dir), 32'h0);
`else
    check_eq("wasd_w", 32'(dir), 32'h3);
`endif
    send(8'hF0); send(8'h1D); idle(2);

    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h75); idle(2);
    check_eq("reset_mid_seq", 32'(dir), 32'(INIT));

    idle(2);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
